// File: rtl/lb_uart_tx.sv
// -----------------------------------------------------------------------------
// lb_uart_tx
//   UART transmitter. Serialises one byte per frame onto txd: start bit, data
//   bits LSB first, optional parity bit, then one or two stop bits. The bit
//   period (in clk cycles, minus one) comes from the baud-select table and is
//   latched when a byte is accepted, so it stays constant for a whole frame.
//
// Parameters
//   DATA_BITS   data bits per frame (5..8)
//   STOP_BITS   stop bits per frame (1 or 2)
//   PARITY_EN   1 = insert a parity bit after the data bits
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous reset, active low
//   counter_value  in   bit period minus 1, in clk cycles
//   tx_data        in   byte to send (bits above DATA_BITS-1 ignored)
//   tx_valid       in   tx_data valid; accepted when tx_valid & tx_ready
//   tx_ready       out  idle, can accept a byte
//   tx_busy        out  frame in progress (inverse of tx_ready)
//   tx_done        out  one-cycle pulse after the last stop bit
//   txd            out  serial line, idle high
// -----------------------------------------------------------------------------
module lb_uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] counter_value,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        txd
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Only the low DATA_BITS bits of a byte take part in the frame.
    localparam logic [7:0] DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD_SEL   = (PARITY_ODD != 0);

    // Parity bit for a (masked) data word: even parity is the XOR of the
    // bits, odd parity its complement.
    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t      state_r;
    logic [19:0] period_r;
    logic [19:0] cnt_r;
    logic [2:0]  bit_cnt_r;
    logic        stop_cnt_r;
    logic [7:0]  shift_r;
    logic        parity_r;
    logic        txd_r;
    logic        ready_r;
    logic        busy_r;
    logic        done_r;
    logic        bit_end_s;

    // Last clock of the current bit period.
    assign bit_end_s = (cnt_r == period_r);

    // Frame sequencer: bit timing, shifting and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            period_r   <= 20'd0;
            cnt_r      <= 20'd0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            shift_r    <= 8'd0;
            parity_r   <= 1'b0;
            txd_r      <= 1'b1;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // Bit-period counter runs only while a frame is on the line.
            if (state_r != S_IDLE) begin
                cnt_r <= bit_end_s ? 20'd0 : cnt_r + 20'd1;
            end
            case (state_r)
                S_IDLE: begin
                    cnt_r <= 20'd0;
                    if (tx_valid && ready_r) begin
                        state_r    <= S_START;
                        period_r   <= counter_value;
                        shift_r    <= tx_data & DATA_MASK;
                        parity_r   <= parity_of(tx_data & DATA_MASK, ODD_SEL);
                        bit_cnt_r  <= 3'd0;
                        stop_cnt_r <= 1'b0;
                        txd_r      <= 1'b0;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        state_r <= S_DATA;
                        txd_r   <= shift_r[0];
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        shift_r <= shift_r >> 1;
                        if (bit_cnt_r == LAST_DATA) begin
                            if (PARITY_EN != 0) begin
                                state_r <= S_PARITY;
                                txd_r   <= parity_r;
                            end else begin
                                state_r <= S_STOP;
                                txd_r   <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            // Next data bit is the one about to reach bit 0.
                            txd_r     <= shift_r[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end_s) begin
                        state_r <= S_STOP;
                        txd_r   <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        if (stop_cnt_r == LAST_STOP) begin
                            // Done and ready land together so a held byte
                            // leaves exactly one mark clock between frames.
                            state_r <= S_IDLE;
                            done_r  <= 1'b1;
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    txd_r   <= 1'b1;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign txd      = txd_r;
    assign tx_ready = ready_r;
    assign tx_busy  = busy_r;
    assign tx_done  = done_r;

endmodule

// File: tb/tb_lb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_lb_uart_tx
//   Directed bench for lb_uart_tx. Four instances cover the parameter sets:
//   u0 default 8N1, u1 8E1, u2 8O1, u3 7 data bits / 2 stop bits. They share
//   clock, reset, period and data; each has its own tx_valid. Inputs change and
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_lb_uart_tx;

    logic        clk;
    logic        rst_n;
    logic [19:0] counter_value;
    logic [7:0]  tx_data;
    logic [3:0]  valid_v;
    logic [3:0]  ready_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  txd_v;

    int vectors;
    int miscompares;

    logic cap_txd   [0:8191];
    logic cap_done  [0:8191];
    logic cap_ready [0:8191];

    lb_uart_tx u0 (
        .clk(clk), .rst_n(rst_n), .counter_value(counter_value), .tx_data(tx_data),
        .tx_valid(valid_v[0]), .tx_ready(ready_v[0]), .tx_busy(busy_v[0]),
        .tx_done(done_v[0]), .txd(txd_v[0])
    );
    lb_uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst_n(rst_n), .counter_value(counter_value), .tx_data(tx_data),
        .tx_valid(valid_v[1]), .tx_ready(ready_v[1]), .tx_busy(busy_v[1]),
        .tx_done(done_v[1]), .txd(txd_v[1])
    );
    lb_uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .counter_value(counter_value), .tx_data(tx_data),
        .tx_valid(valid_v[2]), .tx_ready(ready_v[2]), .tx_busy(busy_v[2]),
        .tx_done(done_v[2]), .txd(txd_v[2])
    );
    lb_uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .counter_value(counter_value), .tx_data(tx_data),
        .tx_valid(valid_v[3]), .tx_ready(ready_v[3]), .tx_busy(busy_v[3]),
        .tx_done(done_v[3]), .txd(txd_v[3])
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the run stalls.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a byte to instance k and let it be accepted; returns at the
    // falling edge of the first start-bit clock.
    task automatic send(input int k, input logic [7:0] d);
        int waited;
        waited = 0;
        tx_data    = d;
        valid_v[k] = 1'b1;
        while (ready_v[k] !== 1'b1 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (ready_v[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL send_ready_u%0d: tx_ready=%b, expected 1 within 20000 clk", k, ready_v[k]);
        end
        @(posedge clk);
        @(negedge clk);
        valid_v[k] = 1'b0;
    endtask

    // Record n clocks of instance k; optionally change counter_value at clock chg_at.
    task automatic capture(input int k, input int n, input int chg_at, input logic [19:0] chg_val);
        for (int c = 0; c < n; c++) begin
            cap_txd[c]   = txd_v[k];
            cap_done[c]  = done_v[k];
            cap_ready[c] = ready_v[k];
            if (c == chg_at) counter_value = chg_val;
            @(negedge clk);
        end
    endtask

    // Index of the first frame bit whose clocks do not all match, or -1.
    function automatic int frame_err(input logic [0:15] fr, input int nbits, input int per, input int start);
        for (int b = 0; b < nbits; b++) begin
            for (int j = 0; j < per; j++) begin
                if (cap_txd[start + b*per + j] !== fr[b]) return b;
            end
        end
        return -1;
    endfunction

    function automatic int first_done(input int n);
        for (int c = 0; c < n; c++) begin
            if (cap_done[c] === 1'b1) return c;
        end
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int cnt;
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            if (cap_done[c] === 1'b1) cnt++;
        end
        return cnt;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        counter_value = 20'd650;
        tx_data = 8'h00;
        valid_v = 4'h0;
        repeat (3) @(negedge clk);
        vectors++;
        if (txd_v !== 4'hF) begin
            miscompares++; $display("FAIL reset_txd: got %b, expected 1111", txd_v);
        end
        vectors++;
        if (ready_v !== 4'hF) begin
            miscompares++; $display("FAIL reset_ready: got %b, expected 1111", ready_v);
        end
        vectors++;
        if (busy_v !== 4'h0) begin
            miscompares++; $display("FAIL reset_busy: got %b, expected 0000", busy_v);
        end
        vectors++;
        if (done_v !== 4'h0) begin
            miscompares++; $display("FAIL reset_done: got %b, expected 0000", done_v);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({txd_v, ready_v, busy_v, done_v} !== 16'hFF00) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h, expected ff00", {txd_v, ready_v, busy_v, done_v});
        end
    endtask

    task automatic test_basic_frame();
        int e;
        counter_value = 20'd650;
        send(0, 8'h55);
        vectors++;
        if ({busy_v[0], ready_v[0], txd_v[0]} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_start_flags: busy/ready/txd=%b, expected 100", {busy_v[0], ready_v[0], txd_v[0]});
        end
        capture(0, 6512, -1, 20'd0);
        e = frame_err(16'b0101010101_000000, 10, 651, 0);
        vectors++;
        if (e !== -1) begin
            miscompares++; $display("FAIL basic_frame_0x55: bad bit %0d, expected none", e);
        end
        vectors++;
        if (first_done(6512) !== 6510) begin
            miscompares++; $display("FAIL basic_done_pos: got %0d, expected 6510", first_done(6512));
        end
        vectors++;
        if (count_done(6512) !== 1) begin
            miscompares++; $display("FAIL basic_done_count: got %0d, expected 1", count_done(6512));
        end
        vectors++;
        if ({cap_ready[6509], cap_ready[6510], cap_txd[6510]} !== 3'b011) begin
            miscompares++;
            $display("FAIL basic_ready_rise: got %b, expected 011", {cap_ready[6509], cap_ready[6510], cap_txd[6510]});
        end
    endtask

    task automatic test_parity();
        int e;
        counter_value = 20'd0;
        send(1, 8'h07);
        capture(1, 13, -1, 20'd0);
        e = frame_err(16'b01110000011_00000, 11, 1, 0);
        vectors++;
        if (e !== -1) begin
            miscompares++; $display("FAIL even_parity_frame: bad bit %0d, expected none", e);
        end
        vectors++;
        if (first_done(13) !== 11 || cap_txd[11] !== 1'b1) begin
            miscompares++; $display("FAIL even_parity_done: got %0d, expected 11", first_done(13));
        end
        send(2, 8'h07);
        capture(2, 13, -1, 20'd0);
        vectors++;
        if (cap_txd[9] !== 1'b0) begin
            miscompares++; $display("FAIL odd_parity_bit: got %b, expected 0", cap_txd[9]);
        end
        e = frame_err(16'b01110000001_00000, 11, 1, 0);
        vectors++;
        if (e !== -1 || first_done(13) !== 11) begin
            miscompares++; $display("FAIL odd_parity_frame: bad bit %0d done %0d, expected -1 / 11", e, first_done(13));
        end
    endtask

    task automatic test_back_to_back();
        int e;
        int ones;
        counter_value = 20'd3;
        tx_data    = 8'hA5;
        valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 96; c++) begin
            cap_txd[c]  = txd_v[0];
            cap_done[c] = done_v[0];
            if (c == 0)  tx_data = 8'h3C;
            if (c == 41) valid_v[0] = 1'b0;
            if (c == 50) begin tx_data = 8'hFF; valid_v[0] = 1'b1; end
            if (c == 52) valid_v[0] = 1'b0;
            @(negedge clk);
        end
        e = frame_err(16'b0101001011_000000, 10, 4, 0);
        vectors++;
        if (e !== -1) begin
            miscompares++; $display("FAIL b2b_frame1_0xA5: bad bit %0d, expected none", e);
        end
        vectors++;
        if ({cap_txd[40], cap_txd[41]} !== 2'b10) begin
            miscompares++; $display("FAIL b2b_one_mark: clk40/41=%b, expected 10", {cap_txd[40], cap_txd[41]});
        end
        e = frame_err(16'b0001111001_000000, 10, 4, 41);
        vectors++;
        if (e !== -1) begin
            miscompares++; $display("FAIL b2b_frame2_0x3C: bad bit %0d, expected none", e);
        end
        vectors++;
        if (first_done(96) !== 40 || cap_done[81] !== 1'b1 || count_done(96) !== 2) begin
            miscompares++;
            $display("FAIL b2b_done: first %0d count %0d, expected 40 / 2", first_done(96), count_done(96));
        end
        ones = 0;
        for (int c = 81; c < 96; c++) if (cap_txd[c] === 1'b1) ones++;
        vectors++;
        if (ones !== 15) begin
            miscompares++; $display("FAIL b2b_ignored_pulse: mark clocks %0d, expected 15", ones);
        end
    endtask

    task automatic test_period_change();
        int e;
        counter_value = 20'd650;
        send(0, 8'hA5);
        capture(0, 6512, 1000, 20'd324);
        e = frame_err(16'b0101001011_000000, 10, 651, 0);
        vectors++;
        if (e !== -1 || first_done(6512) !== 6510) begin
            miscompares++; $display("FAIL period_keep_651: bad bit %0d done %0d, expected -1 / 6510", e, first_done(6512));
        end
        send(0, 8'h3C);
        capture(0, 3252, -1, 20'd0);
        e = frame_err(16'b0001111001_000000, 10, 325, 0);
        vectors++;
        if (e !== -1 || first_done(3252) !== 3250) begin
            miscompares++; $display("FAIL period_next_325: bad bit %0d done %0d, expected -1 / 3250", e, first_done(3252));
        end
    endtask

    task automatic test_reset_mid_frame();
        int e;
        int ones;
        counter_value = 20'd9;
        send(0, 8'h00);
        repeat (25) @(negedge clk);
        vectors++;
        if (txd_v[0] !== 1'b0) begin
            miscompares++; $display("FAIL rst_pre_data: txd=%b, expected 0", txd_v[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({txd_v[0], ready_v[0], busy_v[0], done_v[0]} !== 4'b1100) begin
            miscompares++;
            $display("FAIL rst_abort: txd/ready/busy/done=%b, expected 1100", {txd_v[0], ready_v[0], busy_v[0], done_v[0]});
        end
        rst_n = 1'b1;
        capture(0, 100, -1, 20'd0);
        ones = 0;
        for (int c = 0; c < 100; c++) if (cap_txd[c] === 1'b1) ones++;
        vectors++;
        if (count_done(100) !== 0 || ones !== 100) begin
            miscompares++; $display("FAIL rst_no_done: done %0d mark %0d, expected 0 / 100", count_done(100), ones);
        end
        send(0, 8'h55);
        capture(0, 102, -1, 20'd0);
        e = frame_err(16'b0101010101_000000, 10, 10, 0);
        vectors++;
        if (e !== -1 || first_done(102) !== 100) begin
            miscompares++; $display("FAIL rst_recover_frame: bad bit %0d done %0d, expected -1 / 100", e, first_done(102));
        end
    endtask

    task automatic test_seven_two();
        int e;
        counter_value = 20'd7;
        send(3, 8'h7F);
        capture(3, 82, -1, 20'd0);
        e = frame_err(16'b0111111111_000000, 10, 8, 0);
        vectors++;
        if (e !== -1 || first_done(82) !== 80) begin
            miscompares++; $display("FAIL d7s2_0x7F: bad bit %0d done %0d, expected -1 / 80", e, first_done(82));
        end
        send(3, 8'h80);
        capture(3, 82, -1, 20'd0);
        e = frame_err(16'b0000000011_000000, 10, 8, 0);
        vectors++;
        if (e !== -1 || first_done(82) !== 80) begin
            miscompares++; $display("FAIL d7s2_bit7_dropped: bad bit %0d done %0d, expected -1 / 80", e, first_done(82));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        valid_v     = 4'h0;
        rst_n       = 1'b0;
        counter_value = 20'd0;
        tx_data     = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_period_change();
        test_reset_mid_frame();
        test_seven_two();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
